float_to_fixed_converter: RTL and testbench



---
 rtl/float_to_fixed_converter_if.sv | 32 +++
 rtl/float_to_fixed_converter.sv | 131 +++++++++++++
 tb/tb_float_to_fixed_converter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/float_to_fixed_converter_if.sv
// Handshake/data bundle for the float-to-fixed converter.
// The master drives the float operand and its valid pulse; the slave returns the result.
interface float_to_fixed_converter_if #(
  parameter int unsigned EXP_LEN      = 8,
  parameter int unsigned MANTISSA_LEN = 23,
  parameter int unsigned OUT_LEN      = 32
);
  logic [EXP_LEN+MANTISSA_LEN:0] a;
  logic                          inp_data_ready;
  logic [OUT_LEN-1:0]            result;
  logic                          result_ready;
  logic                          overflow;
  logic                          busy;

  modport master (
    output a,
    output inp_data_ready,
    input  result,
    input  result_ready,
    input  overflow,
    input  busy
  );

  modport slave (
    input  a,
    input  inp_data_ready,
    output result,
    output result_ready,
    output overflow,
    output busy
  );
endinterface

// File: rtl/float_to_fixed_converter.sv
// Multi-cycle float -> signed fixed-point converter.
// Truncates toward zero, saturates on overflow and on Inf/NaN, flushes zero/denormals to 0.
module float_to_fixed_converter #(
  parameter int unsigned EXP_LEN      = 8,
  parameter int unsigned MANTISSA_LEN = 23,
  parameter int unsigned OUT_LEN      = 32,
  parameter int unsigned FRAC_LEN     = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  float_to_fixed_converter_if.slave bus
);

  localparam int unsigned IN_LEN = EXP_LEN + MANTISSA_LEN + 1;
  // Wide enough for exponent range plus every constant offset, with sign.
  localparam int unsigned SW     = EXP_LEN + $clog2(MANTISSA_LEN + OUT_LEN + FRAC_LEN + 1) + 2;
  // Staging width so left shifts never wrap back into the kept bits.
  localparam int unsigned WIDE   = MANTISSA_LEN + 1 + OUT_LEN;
  localparam int          BIAS   = (2 ** (EXP_LEN - 1)) - 1;

  localparam logic signed [SW-1:0] ShiftOfs =
    SW'(int'(FRAC_LEN) - int'(MANTISSA_LEN) - BIAS);
  localparam logic signed [SW-1:0] MantOfs  = SW'(MANTISSA_LEN);
  localparam logic signed [SW-1:0] TopLim   = SW'(OUT_LEN - 1);
  localparam logic [OUT_LEN-1:0]   MaxPos   = {1'b0, {(OUT_LEN-1){1'b1}}};
  localparam logic [OUT_LEN-1:0]   MinNeg   = {1'b1, {(OUT_LEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StDecode, StShift, StSign, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [IN_LEN-1:0]     r_a;
  logic signed [SW-1:0]  r_shift;
  logic                  r_zero, r_special, r_ovf;
  logic [OUT_LEN-1:0]    r_mag, r_res, r_result;
  logic                  r_overflow, r_ready;

  logic                    w_sign;
  logic [EXP_LEN-1:0]      w_exp;
  logic [MANTISSA_LEN-1:0] w_frac;
  logic signed [SW-1:0]    w_shift, w_top;
  logic [SW-1:0]           w_amt;
  logic [WIDE-1:0]         w_wide;
  logic [OUT_LEN-1:0]      w_mag, w_res;
  logic                    w_ovf_cond;

  assign w_sign = r_a[IN_LEN-1];
  assign w_exp  = r_a[IN_LEN-2 -: EXP_LEN];
  assign w_frac = r_a[MANTISSA_LEN-1:0];

  assign w_shift = $signed({{(SW-EXP_LEN){1'b0}}, w_exp}) + ShiftOfs;
  assign w_top   = r_shift + MantOfs;
  // -2^(OUT_LEN-1) exactly is representable, so it escapes the overflow test.
  assign w_ovf_cond = (w_top > TopLim) ||
                      ((w_top == TopLim) && !(w_sign && (w_frac == '0)));
  assign w_amt  = r_shift[SW-1] ? SW'(-r_shift) : SW'(r_shift);
  assign w_wide = {{OUT_LEN{1'b0}}, 1'b1, w_frac};
  assign w_mag  = r_shift[SW-1] ? OUT_LEN'(w_wide >> w_amt) : OUT_LEN'(w_wide << w_amt);

  // Final signed value: saturation wins, then zero flush, then optional negation.
  always_comb begin
    w_res = r_mag;
    if (r_ovf) begin
      w_res = w_sign ? MinNeg : MaxPos;
    end else if (r_zero) begin
      w_res = '0;
    end else if (w_sign) begin
      w_res = (~r_mag) + OUT_LEN'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Linear next-state sequence; only IDLE looks at the input valid.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (bus.inp_data_ready) w_state_next = StDecode;
      StDecode: w_state_next = StShift;
      StShift:  w_state_next = StSign;
      StSign:   w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Per-stage datapath registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_shift    <= '0;
      r_zero     <= 1'b0;
      r_special  <= 1'b0;
      r_mag      <= '0;
      r_ovf      <= 1'b0;
      r_res      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= (r_state == StDone);
      case (r_state)
        StIdle:   if (bus.inp_data_ready) r_a <= bus.a;
        StDecode: begin
          r_shift   <= w_shift;
          r_zero    <= (w_exp == '0);
          r_special <= &w_exp;
        end
        StShift: begin
          r_mag <= w_mag;
          r_ovf <= r_special | (!r_zero & w_ovf_cond);
        end
        StSign:   r_res <= w_res;
        StDone: begin
          r_result   <= r_res;
          r_overflow <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.result       = r_result;
  assign bus.overflow     = r_overflow;
  assign bus.result_ready = r_ready;
  assign bus.busy         = (r_state != StIdle);

endmodule

// File: tb/tb_float_to_fixed_converter.sv
// Directed bench for float_to_fixed_converter with default 8/23/32/16 parameters.
module tb_float_to_fixed_converter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  float_to_fixed_converter_if #(.EXP_LEN(8), .MANTISSA_LEN(23), .OUT_LEN(32)) u_if ();

  float_to_fixed_converter #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .OUT_LEN(32), .FRAC_LEN(16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept at edge 0, then check the 4-cycle latency, the pulse and the result.
  task automatic convert(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_res, input logic exp_ovf);
    @(negedge clk);
    u_if.a = a;
    u_if.inp_data_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.inp_data_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) check({tag, ".ready"}, 32'(u_if.result_ready), 32'd1);
      else if (u_if.result_ready !== 1'b0) check({tag, ".early"}, 32'(u_if.result_ready), 32'd0);
    end
    check({tag, ".result"}, u_if.result, exp_res);
    check({tag, ".ovf"}, 32'(u_if.overflow), 32'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, ".pulse_end"}, 32'(u_if.result_ready), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.a = '0;
    u_if.inp_data_ready = 1'b0;
    #12;
    check("rst.result", u_if.result, 32'h0);
    check("rst.ready", 32'(u_if.result_ready), 32'd0);
    check("rst.ovf", 32'(u_if.overflow), 32'd0);
    check("rst.busy", 32'(u_if.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic values.
    convert("one",     32'h3F800000, 32'h00010000, 1'b0);
    convert("neg2p5",  32'hC0200000, 32'hFFFD8000, 1'b0);
    convert("tenth",   32'h3DCCCCCD, 32'h00001999, 1'b0);
    // Boundaries.
    convert("minneg",  32'hC7000000, 32'h80000000, 1'b0);
    convert("pos40k",  32'h471C4000, 32'h7FFFFFFF, 1'b1);
    convert("neg40k",  32'hC71C4000, 32'h80000000, 1'b1);
    // Specials.
    convert("pzero",   32'h00000000, 32'h00000000, 1'b0);
    convert("nzero",   32'h80000000, 32'h00000000, 1'b0);
    convert("denorm",  32'h00400000, 32'h00000000, 1'b0);
    convert("pinf",    32'h7F800000, 32'h7FFFFFFF, 1'b1);
    convert("ninf",    32'hFF800000, 32'h80000000, 1'b1);
    convert("nan",     32'h7FC00000, 32'h7FFFFFFF, 1'b1);
    convert("tiny",    32'h33800000, 32'h00000000, 1'b0);
    convert("m1p5",    32'hBFC00000, 32'hFFFE8000, 1'b0);

    // Back-to-back with valid held high; operand changes after edge 2.
    @(negedge clk);
    u_if.a = 32'h3F800000;
    u_if.inp_data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs.busy0", 32'(u_if.busy), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) u_if.a = 32'h40000000;
      if (k == 5) u_if.inp_data_ready = 1'b0;
      check($sformatf("hs.busy%0d", k), 32'(u_if.busy), (k == 4 || k == 9) ? 32'd0 : 32'd1);
      check($sformatf("hs.ready%0d", k), 32'(u_if.result_ready),
            (k == 4 || k == 9) ? 32'd1 : 32'd0);
      if (k == 4) check("hs.first", u_if.result, 32'h00010000);
      if (k == 9) check("hs.second", u_if.result, 32'h00020000);
    end

    // Reset during SHIFT aborts the conversion.
    @(negedge clk);
    u_if.a = 32'h3F800000;
    u_if.inp_data_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.inp_data_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.result", u_if.result, 32'h0);
    check("mid.busy", 32'(u_if.busy), 32'd0);
    check("mid.ovf", 32'(u_if.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (u_if.result_ready !== 1'b0 || u_if.busy !== 1'b0)
        check("mid.quiet", {30'd0, u_if.result_ready, u_if.busy}, 32'd0);
    end
    check("mid.still0", u_if.result, 32'h0);
    convert("after_rst", 32'h3F800000, 32'h00010000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
